// File: rtl/axil_master_engine_if.sv
// axil_master_engine_if: command/response and AXI4-Lite channel bundle for axil_master_engine
interface axil_master_engine_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_wstrb;
    logic              rsp_valid, rsp_ready, rsp_timeout;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
    logic              m_axi_awvalid, m_axi_awready;
    logic [DATA_W-1:0] m_axi_wdata, m_axi_rdata;
    logic [STRB_W-1:0] m_axi_wstrb;
    logic              m_axi_wvalid, m_axi_wready;
    logic [1:0]        m_axi_bresp, m_axi_rresp;
    logic              m_axi_bvalid, m_axi_bready;
    logic              m_axi_arvalid, m_axi_arready;
    logic              m_axi_rvalid, m_axi_rready;
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready
    );
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready
    );
endinterface

// File: rtl/axil_master_engine.sv
// axil_master_engine: single-beat AXI4-Lite master; define AXIL_MST_TIMEOUT_EN to bound transactions by TIMEOUT_CYC
module axil_master_engine #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_aresetn,
    axil_master_engine_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [1:0]        resp_q, resp_d;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic              arvalid_q, arvalid_d, rready_q, rready_d, tmo_q, tmo_d;
    logic              aw_left, w_left, timeout;
    assign aw_left = awvalid_q && !bus.m_axi_awready;
    assign w_left  = wvalid_q && !bus.m_axi_wready;
`ifdef AXIL_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             busy, progress;
    assign busy = state_q inside {WR_REQ, WR_RESP, RD_ADDR, RD_DATA};
    assign progress = (state_q == WR_REQ)  ? !aw_left && !w_left :
                      (state_q == WR_RESP) ? bus.m_axi_bvalid :
                      (state_q == RD_ADDR) ? bus.m_axi_arready :
                      (state_q == RD_DATA) && bus.m_axi_rvalid;
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn || (state_q == IDLE && bus.cmd_valid)) cnt_q <= '0;
        else if (busy) cnt_q <= cnt_q + 1'b1;
    end
    // a handshake landing on the final cycle still wins
    assign timeout = busy && cnt_q == CNT_W'(TIMEOUT_CYC - 1) && !progress;
`else
    logic unused_cfg;
    assign unused_cfg = TIMEOUT_CYC > 1;
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        awaddr_d = awaddr_q;
        araddr_d = araddr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        resp_d = resp_q;
        tmo_d = tmo_q;
        awvalid_d = awvalid_q;
        wvalid_d = wvalid_q;
        bready_d = bready_q;
        arvalid_d = arvalid_q;
        rready_d = rready_q;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                tmo_d = 1'b0;
                if (bus.cmd_write) begin
                    state_d = WR_REQ;
                    awaddr_d = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    wstrb_d = bus.cmd_wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d = 1'b1;
                end else begin
                    state_d = RD_ADDR;
                    araddr_d = bus.cmd_addr;
                    arvalid_d = 1'b1;
                end
            end
            WR_REQ: begin
                awvalid_d = aw_left;
                wvalid_d = w_left;
                if (!aw_left && !w_left) begin
                    state_d = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: if (bus.m_axi_bvalid) begin
                state_d = RSP;
                bready_d = 1'b0;
                resp_d = bus.m_axi_bresp;
                rdata_d = '0;
            end
            RD_ADDR: if (bus.m_axi_arready) begin
                state_d = RD_DATA;
                arvalid_d = 1'b0;
                rready_d = 1'b1;
            end
            RD_DATA: if (bus.m_axi_rvalid) begin
                state_d = RSP;
                rready_d = 1'b0;
                resp_d = bus.m_axi_rresp;
                rdata_d = bus.m_axi_rdata;
            end
            RSP: state_d = bus.rsp_ready ? IDLE : RSP;
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = RSP;
            awvalid_d = 1'b0;
            wvalid_d = 1'b0;
            bready_d = 1'b0;
            arvalid_d = 1'b0;
            rready_d = 1'b0;
            tmo_d = 1'b1;
            resp_d = 2'b10;
            rdata_d = '0;
        end
    end
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state_q <= IDLE;
            awaddr_q <= '0;
            araddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q <= '0;
            tmo_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q <= 1'b0;
            bready_q <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            awaddr_q <= awaddr_d;
            araddr_q <= araddr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            resp_q <= resp_d;
            tmo_q <= tmo_d;
            awvalid_q <= awvalid_d;
            wvalid_q <= wvalid_d;
            bready_q <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q <= rready_d;
        end
    end
    assign bus.cmd_ready     = state_q == IDLE;
    assign bus.rsp_valid     = state_q == RSP;
    assign bus.rsp_rdata     = rdata_q;
    assign bus.rsp_resp      = resp_q;
    assign bus.rsp_timeout   = tmo_q;
    assign bus.m_axi_awaddr  = awaddr_q;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;
endmodule

// File: tb/tb_axil_master_engine.sv
// tb_axil_master_engine: directed checks of axil_master_engine (timeout steps need AXIL_MST_TIMEOUT_EN)
module tb_axil_master_engine;
    logic clk = 1'b0;
    logic aresetn = 1'b0;
    int checks = 0;
    int failures = 0;
    axil_master_engine_if #(.ADDR_W(4), .DATA_W(32)) bus ();
    axil_master_engine #(.ADDR_W(4), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .s_axi_aclk(clk),
        .s_axi_aresetn(aresetn),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic cmd(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr = a;
        bus.cmd_wdata = d;
        bus.cmd_wstrb = s;
    endtask
    initial begin
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0; bus.cmd_wstrb = 0;
        bus.rsp_ready = 0; bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_bresp = 0;
        bus.m_axi_bvalid = 0; bus.m_axi_arready = 0; bus.m_axi_rdata = 0; bus.m_axi_rresp = 0;
        bus.m_axi_rvalid = 0;
        tick(); tick();
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_valids", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid}, 0);
        chk("rst_readies", {bus.m_axi_bready, bus.m_axi_rready}, 0);
        chk("rst_payload", {bus.m_axi_awaddr, bus.m_axi_wdata, bus.m_axi_wstrb}, 0);
        chk("rst_rsp", {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout}, 0);
        aresetn = 1'b1;
        tick();
        // minimum-latency write; early bvalid in IDLE must be ignored
        cmd(1, 4'h4, 32'h41, 4'b0001);
        bus.m_axi_awready = 1; bus.m_axi_wready = 1; bus.m_axi_bvalid = 1; bus.rsp_ready = 1;
        tick();
        bus.cmd_valid = 0;
        chk("w1_aw_w_valid", {bus.m_axi_awvalid, bus.m_axi_wvalid}, 2'b11);
        chk("w1_payload", {bus.m_axi_awaddr, bus.m_axi_wdata, bus.m_axi_wstrb}, {4'h4, 32'h41, 4'b0001});
        chk("w1_cmd_ready", bus.cmd_ready, 0);
        chk("w1_bready_n1", bus.m_axi_bready, 0);
        tick();
        chk("w1_valids_drop", {bus.m_axi_awvalid, bus.m_axi_wvalid}, 0);
        chk("w1_bready", bus.m_axi_bready, 1);
        chk("w1_no_rsp_n2", bus.rsp_valid, 0);
        tick();
        bus.m_axi_bvalid = 0;
        chk("w1_rsp_valid", bus.rsp_valid, 1);
        chk("w1_rsp", {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout}, 0);
        chk("w1_bready_drop", bus.m_axi_bready, 0);
        tick();
        chk("w1_rsp_done", bus.rsp_valid, 0);
        chk("w1_cmd_ready_back", bus.cmd_ready, 1);
        // read with 3-cycle arready delay, then 5-cycle response stall
        bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.rsp_ready = 0;
        cmd(0, 4'h8, 32'h0, 4'h0);
        tick();
        bus.cmd_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("r_arvalid_wait", {bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_rready}, {1'b1, 4'h8, 1'b0});
            tick();
        end
        chk("r_arvalid_held", bus.m_axi_arvalid, 1);
        bus.m_axi_arready = 1;
        tick();
        bus.m_axi_arready = 0;
        chk("r_ar_done", {bus.m_axi_arvalid, bus.m_axi_rready}, 2'b01);
        bus.m_axi_rvalid = 1; bus.m_axi_rdata = 32'h5; bus.m_axi_rresp = 2'b00;
        tick();
        bus.m_axi_rvalid = 0; bus.m_axi_rdata = 32'hDEAD_BEEF; bus.m_axi_rresp = 2'b11;
        chk("r_rready_drop", bus.m_axi_rready, 0);
        cmd(1, 4'hC, 32'h1234_5678, 4'b1100);
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_resp}, {1'b1, 32'h5, 2'b00});
            chk("stall_quiet", {bus.cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid}, 0);
            tick();
        end
        bus.rsp_ready = 1;
        tick();
        bus.rsp_ready = 0;
        chk("stall_released", {bus.rsp_valid, bus.cmd_ready, bus.m_axi_awvalid}, 3'b010);
        // W accepted two cycles ahead of AW, bresp=01
        bus.m_axi_wready = 1;
        tick();
        bus.cmd_valid = 0;
        chk("w2_both_valid", {bus.m_axi_awvalid, bus.m_axi_wvalid}, 2'b11);
        tick();
        bus.m_axi_wready = 0;
        chk("w2_w_drop", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready}, 3'b100);
        tick();
        chk("w2_aw_held", {bus.m_axi_awvalid, bus.m_axi_awaddr, bus.m_axi_bready}, {1'b1, 4'hC, 1'b0});
        bus.m_axi_awready = 1;
        tick();
        bus.m_axi_awready = 0;
        chk("w2_bready", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready}, 3'b001);
        bus.m_axi_bvalid = 1; bus.m_axi_bresp = 2'b01;
        tick();
        bus.m_axi_bvalid = 0;
        chk("w2_rsp", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_resp}, {1'b1, 32'h0, 2'b01});
        bus.rsp_ready = 1;
        tick();
        bus.rsp_ready = 0;
        chk("w2_single_rsp", bus.rsp_valid, 0);
`ifdef AXIL_MST_TIMEOUT_EN
        cmd(0, 4'h2, 32'h0, 4'h0);
        tick();
        bus.cmd_valid = 0;
        for (int i = 0; i < 16; i++) begin
            chk("to_arvalid", {bus.m_axi_arvalid, bus.rsp_valid}, 2'b10);
            tick();
        end
        chk("to_arvalid_drop", bus.m_axi_arvalid, 0);
        chk("to_rsp", {bus.rsp_valid, bus.rsp_timeout, bus.rsp_resp, bus.rsp_rdata}, {1'b1, 1'b1, 2'b10, 32'h0});
        bus.rsp_ready = 1;
        tick();
        bus.rsp_ready = 0;
        cmd(0, 4'h6, 32'h0, 4'h0);
        bus.m_axi_arready = 1; bus.m_axi_rvalid = 1; bus.m_axi_rdata = 32'hA5; bus.m_axi_rresp = 2'b00;
        tick();
        bus.cmd_valid = 0;
        tick();
        tick();
        bus.m_axi_arready = 0; bus.m_axi_rvalid = 0;
        chk("to_next_read", {bus.rsp_valid, bus.rsp_timeout, bus.rsp_resp, bus.rsp_rdata}, {1'b1, 1'b0, 2'b00, 32'hA5});
        bus.rsp_ready = 1;
        tick();
        bus.rsp_ready = 0;
`endif
        // reset while waiting in WR_RESP
        cmd(1, 4'h1, 32'h77, 4'hF);
        bus.m_axi_awready = 1; bus.m_axi_wready = 1;
        tick();
        bus.cmd_valid = 0;
        tick();
        chk("rr_bready", bus.m_axi_bready, 1);
        aresetn = 0; bus.m_axi_bvalid = 1;
        tick();
        chk("rr_outputs", {bus.m_axi_bready, bus.rsp_valid, bus.m_axi_awvalid, bus.m_axi_wvalid}, 0);
        chk("rr_payload", {bus.m_axi_awaddr, bus.m_axi_wdata, bus.m_axi_wstrb, bus.rsp_rdata, bus.rsp_resp}, 0);
        aresetn = 1;
        tick();
        chk("rr_cmd_ready", {bus.cmd_ready, bus.rsp_valid, bus.m_axi_bready}, 3'b100);
        bus.m_axi_bvalid = 0;
        tick();
        chk("rr_no_rsp", bus.rsp_valid, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axil_master_engine.md
Name: axil_master_engine

Overview:
- Synthesisable AXI4-Lite master that turns single-beat read/write commands into fully handshaked AXI4-Lite transactions.
- Replaces the fixed 4-bit-address / 32-bit-data, strobe-hardwired bus driving used to exercise the UART register block.
- Sits between a command source (bench sequencer or on-chip controller) and any AXI4-Lite slave, e.g. the UART register file.
- Generalises address/data width and accepts AW and W independently in either order. Optionally bounds every transaction with a timeout.

Parameters:
- ADDR_W, 4, AXI address width in bits (1..32).
- DATA_W, 32, AXI data width; 32 or 64 only; STRB_W = DATA_W/8.
- TIMEOUT_CYC, 256, cycles before an unanswered transaction is abandoned (>=2; used only with AXIL_MST_TIMEOUT_EN).

Ports:
- s_axi_aclk  in  1  clock; all logic on rising edge
- s_axi_aresetn  in  1  synchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  STRB_W  write byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- rsp_timeout  out  1  transaction abandoned by timeout
- m_axi_awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  write-address channel
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_W/STRB_W/1/1  write-data channel
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write-response channel
- m_axi_araddr/arvalid/arready  out/out/in  ADDR_W/1/1  read-address channel
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1  read-data channel

Behaviour:
- Reset: sampled on the rising edge while s_axi_aresetn=0; takes effect on that edge from any state, including mid-transaction.
- Reset values: state=IDLE; every valid/ready output 0; rsp_rdata=0, rsp_resp=0, rsp_timeout=0; timeout counter=0.
- All m_axi_* payload outputs are registered and 0 out of reset.
- cmd_ready = (state==IDLE), decoded from the state register. No skid buffer; one transaction in flight at a time.
- IDLE: on cmd handshake at edge N, latch addr/wdata/wstrb.
  - Write -> WR_REQ with awvalid=wvalid=1 from cycle N+1.
  - Read -> RD_ADDR with arvalid=1 from N+1.
- WR_REQ: AW and W are tracked independently via aw_done and w_done flags.
  - awvalid drops on the edge its handshake completes; likewise wvalid.
  - Both handshakes in the same cycle are legal.
  - Payload is stable while valid is high; valid is never withdrawn before its handshake.
  - When both are done -> WR_RESP, bready=1.
- WR_RESP: on bvalid & bready, capture bresp and set rsp_rdata=0; bready=0; -> RSP.
- RD_ADDR: on arvalid & arready, arvalid=0, rready=1 -> RD_DATA.
- RD_DATA: on rvalid & rready, capture rdata/rresp; rready=0 -> RSP.
- RSP: rsp_valid=1; all fields held stable until rsp_ready. On handshake -> IDLE, so the next command can be accepted the following cycle.
- Minimum latency with an always-ready slave:
  - Write: cmd handshake at N, AW/W at N+1, B at N+2, rsp_valid at N+3.
  - Read: same timing with AR and R.
- Ignored inputs:
  - bvalid/rvalid arriving outside WR_RESP/RD_DATA.
  - cmd_* while not in IDLE.
- Back-pressure: rsp_ready held low stalls indefinitely in RSP with no AXI activity.

Optional Feature:
- Macro: AXIL_MST_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYC+1)-bit counter clears on the cmd handshake and increments every cycle in WR_REQ/WR_RESP/RD_ADDR/RD_DATA.
  - When it reaches TIMEOUT_CYC-1 and the pending handshake has not completed that cycle, the transaction is abandoned on that edge: all m_axi valids/readies go to 0 and the block enters RSP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
  - A handshake completing in that same cycle wins over the timeout.
  - Deliberate protocol abandonment; intended for bench use against hung slaves.
- Undefined: no counter logic; rsp_timeout is tied to 0; transactions wait indefinitely.

Test Plan:
- Write addr 4'h4, data 32'h41, strb 4'b0001, slave awready=wready=bready path all immediate, bresp=00 -> AW/W at N+1, rsp_valid at N+3 with rsp_resp=00, rsp_rdata=0.
- Write where slave asserts wready 2 cycles before awready -> wvalid drops after its handshake, awvalid held stable until accepted, exactly one rsp, bready only after both handshakes.
- Read addr 4'h8, slave returns rdata 32'h0000_0005, rresp=00 after 3-cycle arready delay -> rsp_rdata=5, rsp_resp=00, arvalid never dropped early.
- rsp_ready held low 5 cycles after a read -> rsp_valid and rsp_rdata stable, cmd_ready=0, no m_axi valid asserted; the next command is accepted the cycle after the handshake.
- AXIL_MST_TIMEOUT_EN, TIMEOUT_CYC=16, slave never asserts arready -> arvalid high exactly 16 cycles, then rsp_timeout=1, rsp_resp=10, rsp_rdata=0; a subsequent normal read completes correctly.
- s_axi_aresetn=0 for one edge while in WR_RESP with bready=1 -> all outputs reset values on that edge, cmd_ready=1 the cycle after release, no rsp_valid generated.
